// File: rtl/uart_rx_top.sv
// Buffered 8N1 UART receiver. A two-flop synchronizer feeds a four-state
// receive FSM. Each completed frame is pushed as {frame_err, byte} into a
// show-ahead FIFO that the host drains with read_en.
module uart_rx_top #(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] baud_div,
   input  logic        rx,
   input  logic        read_en,
   output logic [8:0]  data_out,
   output logic        empty,
   output logic        full,
   output logic        overrun,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic          rx_meta_q, rxs_q, rxs_d_q;
   state_e        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [15:0]   half_lim, full_lim;
   logic          push, frame_err;

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          pop, do_push, drop;

   assign half_lim = (baud_div >> 1) - 16'd1;
   assign full_lim = baud_div - 16'd1;

   // Synchronize rx and keep one extra stage for falling-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         rxs_d_q   <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
         rxs_d_q   <= rxs_q;
      end
   end

   // Receive FSM state, bit counter, bit index and shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic. The >= compares keep the FSM bounded if baud_div
   // shrinks mid-frame.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      idx_d     = idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            // Edge-triggered so a line stuck low does not re-arm
            if (rxs_d_q && !rxs_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q >= half_lim) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs_q ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q >= full_lim) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q >= full_lim) begin
               cnt_d     = '0;
               push      = 1'b1;
               frame_err = ~rxs_q;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign pop     = read_en && !empty;
   // A pop in the same cycle frees the slot, so a push while full still lands
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;

   // FIFO storage; contents are don't-care while count is zero
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {frame_err, shift_d};
   end

   // FIFO pointers, occupancy and sticky overrun flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overrun  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !pop)      count_q <= count_q + 1'b1;
         else if (!do_push && pop) count_q <= count_q - 1'b1;
         if (drop)     overrun <= 1'b1;
         else if (pop) overrun <= 1'b0;
      end
   end

   // Show-ahead head entry, forced to zero when empty
   always_comb begin
      data_out = '0;
      if (!empty) data_out = mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: a behavioural serializer drives rx,
// expected entries go into a scoreboard queue and are compared on read.
module tb_uart_rx_top;

   logic        clk;
   logic        rst;
   logic [15:0] baud_div;
   logic        rx;
   logic        read_en;
   logic [8:0]  data_out;
   logic        empty;
   logic        full;
   logic        overrun;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q [$];

   uart_rx_top #(.DEPTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_div (baud_div),
      .rx       (rx),
      .read_en  (read_en),
      .data_out (data_out),
      .empty    (empty),
      .full     (full),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Serialize one frame; a 0 stop bit leaves the line low afterwards
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit store);
      if (store) exp_q.push_back({~stop, b});
      rx = 1'b0;
      wait_cycles(int'(baud_div));
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cycles(int'(baud_div));
      end
      rx = stop;
      wait_cycles(int'(baud_div));
      wait_cycles(4);
   endtask

   // Compare head against scoreboard and pop it
   task automatic read_check(input string name);
      logic [8:0] exp;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
      checks++;
      if (empty !== 1'b0) begin
         errors++;
         $display("FAIL %s: empty=%b, required 0 (expected entry %h)", name, empty, exp);
      end else if (data_out !== exp) begin
         errors++;
         $display("FAIL %s: data_out=%h, required %h", name, data_out, exp);
      end
      read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; rx = 1'b1; read_en = 1'b0; baud_div = 16'd16;
      wait_cycles(3);
      checks++;
      if ({empty, full, overrun, busy, data_out} !== {4'b1000, 9'h000}) begin
         errors++;
         $display("FAIL reset: e/f/o/b/d=%b%b%b%b/%h, required 1000/000",
                  empty, full, overrun, busy, data_out);
      end
      rst = 1'b1;
      wait_cycles(3);
   endtask

   task automatic test_basic();
      int lat;
      bit prev_busy;
      baud_div = 16'd16;
      lat = 0;
      prev_busy = 1'b0;
      fork
         send_frame(8'hA5, 1'b1, 1'b1);
         begin
            for (int i = 1; i <= 400; i++) begin
               @(negedge clk);
               if (!empty) begin
                  lat = i;
                  break;
               end
               prev_busy = busy;
            end
         end
      join
      checks++;
      if (lat != 155) begin
         errors++;
         $display("FAIL push_latency: %0d cycles, required 155", lat);
      end
      checks++;
      if (prev_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_stop: busy=%b, required 1", prev_busy);
      end
      read_check("basic_a5");
      checks++;
      if (empty !== 1'b1 || data_out !== 9'h000) begin
         errors++;
         $display("FAIL basic_drained: empty=%b data_out=%h, required 1/000", empty, data_out);
      end
   endtask

   task automatic test_false_start();
      rx = 1'b0;
      wait_cycles(4);
      rx = 1'b1;
      wait_cycles(6);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL false_start_busy: busy=%b, required 1", busy);
      end
      wait_cycles(1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL false_start_idle: busy=%b, required 0", busy);
      end
      wait_cycles(200);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL false_start_nopush: empty=%b, required 1", empty);
      end
   endtask

   task automatic test_frame_error();
      send_frame(8'h3C, 1'b0, 1'b1);
      read_check("frame_err_3c");
      wait_cycles(400);
      checks++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL line_low_no_retrigger: busy=%b empty=%b, required 0/1", busy, empty);
      end
      rx = 1'b1;
      wait_cycles(64);
      send_frame(8'h77, 1'b1, 1'b1);
      read_check("after_frame_err_77");
   endtask

   task automatic test_overrun();
      baud_div = 16'd8;
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b1);
      checks++;
      if (full !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL full_after_8: full=%b overrun=%b, required 1/0", full, overrun);
      end
      send_frame(8'h09, 1'b1, 1'b0);
      checks++;
      if (full !== 1'b1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_after_9: full=%b overrun=%b, required 1/1", full, overrun);
      end
      read_check("ovr_read_1");
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
      end
      for (int i = 2; i <= 8; i++) read_check("ovr_read");
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL ovr_drained: empty=%b, required 1", empty);
      end
   endtask

   task automatic test_push_pop_full();
      logic [8:0] exp;
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b1);
      fork
         send_frame(8'h09, 1'b1, 1'b1);
         begin
            // Stop sample edge is 3 + (8>>1) + 9*8 = 79 cycles after rx falls
            wait_cycles(78);
            exp = exp_q.pop_front();
            checks++;
            if (data_out !== exp) begin
               errors++;
               $display("FAIL pp_head: data_out=%h, required %h", data_out, exp);
            end
            read_en = 1'b1;
            @(negedge clk);
            read_en = 1'b0;
         end
      join
      checks++;
      if (full !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL pp_full: full=%b overrun=%b, required 1/0", full, overrun);
      end
      for (int i = 2; i <= 9; i++) read_check("pp_read");
   endtask

   task automatic test_reset_mid_frame();
      baud_div = 16'd16;
      send_frame(8'h11, 1'b1, 1'b0);
      rx = 1'b0;
      wait_cycles(16);
      rx = 1'b1;
      wait_cycles(16);
      rx = 1'b0;
      wait_cycles(10);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: busy=%b empty=%b, required 0/1", busy, empty);
      end
      rx = 1'b1;
      wait_cycles(3);
      rst = 1'b1;
      wait_cycles(40);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL no_partial: empty=%b, required 1", empty);
      end
      send_frame(8'h5A, 1'b1, 1'b1);
      read_check("after_reset_5a");
   endtask

   task automatic test_loopback(input int bd, input int n);
      baud_div = 16'(bd);
      for (int i = 0; i < n; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
         read_check("loopback");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_error();
      test_overrun();
      test_push_pop_full();
      test_reset_mid_frame();
      test_loopback(4, 32);
      test_loopback(1000, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
